// File: rtl/mod_mem_store_buffer.sv
// Posted store buffer: derives byte-enables, queues stores in a FIFO and
// drains them in order over a req/gnt handshake; flags word-level load hits.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif
`ifndef FUNCT3_SB
`define FUNCT3_SB 3'b000
`endif
`ifndef FUNCT3_SH
`define FUNCT3_SH 3'b001
`endif
`ifndef FUNCT3_SW
`define FUNCT3_SW 3'b010
`endif

module mod_mem_store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     st_valid_i,
  output logic                     st_ready_o,
  input  logic [`FUNCT3_WIDTH-1:0] st_funct3_i,
  input  logic [`XLEN-1:0]         st_addr_i,
  input  logic [`XLEN-1:0]         st_data_i,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  output logic [`XLEN-1:0]         mem_addr_o,
  output logic [`XLEN-1:0]         mem_wdata_o,
  output logic [3:0]               mem_be_o,
  input  logic [`XLEN-1:0]         ld_check_addr_i,
  output logic                     ld_conflict_o,
  output logic                     empty_o
);

  localparam int unsigned XW = `XLEN;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [XW-1:0] addr;
    logic [XW-1:0] data;
    logic [3:0]    be;
  } entry_t;

  entry_t        entry_q [DEPTH];
  entry_t        entry_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] count;
  logic          full;
  logic          empty;
  logic [3:0]    be_c;
  logic          f3_ok_c;
  logic          enq;
  logic          deq;
  entry_t        new_entry;
  logic          unused_ld_lsb;

  // Occupancy from pointers: extra MSB separates full from empty
  assign count = tail_q - head_q;
  assign empty = (head_q == tail_q);
  assign full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);

  assign st_ready_o  = !full;
  assign mem_req_o   = !empty;
  assign empty_o     = empty;
  assign mem_addr_o  = entry_q[head_q[AW-1:0]].addr;
  assign mem_wdata_o = entry_q[head_q[AW-1:0]].data;
  assign mem_be_o    = entry_q[head_q[AW-1:0]].be;

  // Word-granular match only; the byte offset of the load is irrelevant
  assign unused_ld_lsb = ^ld_check_addr_i[1:0];

  // Byte-enable derivation from store width and byte offset
  always_comb begin
    be_c    = 4'b0000;
    f3_ok_c = 1'b1;
    case (st_funct3_i)
      `FUNCT3_SB: be_c = 4'b0001 << st_addr_i[1:0];
      `FUNCT3_SH: be_c = (st_addr_i[1:0] == 2'b00) ? 4'b0011 : 4'b1100;
      `FUNCT3_SW: be_c = 4'b1111;
      default:    f3_ok_c = 1'b0;
    endcase
  end

  assign enq = st_valid_i && st_ready_o && f3_ok_c;
  assign deq = mem_req_o && mem_gnt_i;

  // Next-state: write tail entry on enqueue, advance head on retire
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    new_entry.addr = {st_addr_i[XW-1:2], 2'b00};
    new_entry.data = st_data_i;
    new_entry.be   = be_c;
    if (enq) begin
      entry_d[tail_q[AW-1:0]] = new_entry;
      tail_d = tail_q + PW'(1);
    end
    if (deq) begin
      head_d = head_q + PW'(1);
    end
  end

  // Pointer and storage registers; reset discards and clears all entries
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // Load hazard: any occupied slot (including the retiring head) on the same word
  always_comb begin
    logic [AW-1:0] rel;
    ld_conflict_o = 1'b0;
    rel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = AW'(AW'(i) - head_q[AW-1:0]);
      if ((PW'(rel) < count) && (entry_q[i].addr[XW-1:2] == ld_check_addr_i[XW-1:2])) begin
        ld_conflict_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_mem_store_buffer.sv
// Directed self-checking bench for mod_mem_store_buffer.

module tb_mod_mem_store_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [2:0]  st_funct3_i;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] ld_check_addr_i;
  logic        ld_conflict_o;
  logic        empty_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  mod_mem_store_buffer #(.DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_funct3_i(st_funct3_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .ld_check_addr_i(ld_check_addr_i), .ld_conflict_o(ld_conflict_o),
    .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_store(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid_i  = v;
    st_funct3_i = f3;
    st_addr_i   = a;
    st_data_i   = d;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; mem_gnt_i = 1'b0; ld_check_addr_i = 32'h0;
    drive_store(1'b0, SW, 32'h0, 32'h0);
    #2;
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
    n_checks++; if (st_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", st_ready_o); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", mem_req_o); end
    n_checks++; if (ld_conflict_o !== 1'b0) begin n_fail++; $display("FAIL reset_conflict got=%b exp=0", ld_conflict_o); end
    n_checks++; if ({mem_addr_o, mem_wdata_o, mem_be_o} !== 68'h0) begin n_fail++; $display("FAIL reset_fields got=%h/%h/%b exp=0", mem_addr_o, mem_wdata_o, mem_be_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_single_sb();
    mem_gnt_i = 1'b1;
    drive_store(1'b1, SB, 32'h0000_1003, 32'hAB00_0000);
    n_checks++; if (st_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b exp=1", st_ready_o); end
    step();
    drive_store(1'b0, SB, 32'h0, 32'h0);
    n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL single_req got=%b exp=1", mem_req_o); end
    n_checks++; if (mem_addr_o !== 32'h0000_1000) begin n_fail++; $display("FAIL single_addr got=%h exp=00001000", mem_addr_o); end
    n_checks++; if (mem_be_o !== 4'b1000) begin n_fail++; $display("FAIL single_be got=%b exp=1000", mem_be_o); end
    n_checks++; if (mem_wdata_o !== 32'hAB00_0000) begin n_fail++; $display("FAIL single_wdata got=%h exp=ab000000", mem_wdata_o); end
    step();
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL single_empty got=%b exp=1", empty_o); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL single_req_drop got=%b exp=0", mem_req_o); end
  endtask

  task automatic test_fill_order();
    logic [31:0] exp_addr [4];
    logic [3:0]  exp_be   [4];
    logic [2:0]  f3s      [4];
    exp_addr = '{32'h2000, 32'h3000, 32'h4000, 32'h5000};
    exp_be   = '{4'b1100, 4'b1111, 4'b0010, 4'b0011};
    f3s      = '{SH, SW, SB, SH};
    mem_gnt_i = 1'b0;
    drive_store(1'b1, f3s[0], 32'h2002, 32'h1111_0000); step();
    drive_store(1'b1, f3s[1], 32'h3000, 32'h2222_2222); step();
    drive_store(1'b1, f3s[2], 32'h4001, 32'h0000_3300); step();
    drive_store(1'b1, f3s[3], 32'h5000, 32'h0000_4444); step();
    n_checks++; if (st_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_ready got=%b exp=0", st_ready_o); end
    drive_store(1'b1, SB, 32'h6000, 32'h0000_0055);
    step();
    drive_store(1'b0, SB, 32'h0, 32'h0);
    n_checks++; if (mem_addr_o !== 32'h2000 || mem_be_o !== 4'b1100) begin n_fail++; $display("FAIL fill_hold got=%h/%b exp=00002000/1100", mem_addr_o, mem_be_o); end
    mem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (mem_addr_o !== exp_addr[i] || mem_be_o !== exp_be[i] || mem_req_o !== 1'b1)
        begin n_fail++; $display("FAIL fill_order[%0d] got=%h/%b req=%b exp=%h/%b", i, mem_addr_o, mem_be_o, mem_req_o, exp_addr[i], exp_be[i]); end
      step();
    end
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL fill_refused_5th got_empty=%b exp=1", empty_o); end
    mem_gnt_i = 1'b0;
  endtask

  task automatic test_full_simul();
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_store(1'b1, SW, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i)); step();
    end
    n_checks++; if (st_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", st_ready_o); end
    drive_store(1'b1, SW, 32'h200, 32'hDEAD_BEEF);
    mem_gnt_i = 1'b1;
    step();
    drive_store(1'b0, SW, 32'h0, 32'h0);
    mem_gnt_i = 1'b0;
    n_checks++; if (st_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready_after got=%b exp=1", st_ready_o); end
    n_checks++; if (mem_addr_o !== 32'h104 || mem_wdata_o !== 32'hC0DE_0001) begin n_fail++; $display("FAIL full_head got=%h/%h exp=00000104/c0de0001", mem_addr_o, mem_wdata_o); end
    mem_gnt_i = 1'b1;
    step(); step(); step();
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL full_no_enq got_empty=%b exp=1", empty_o); end
    mem_gnt_i = 1'b0;
  endtask

  task automatic test_stream();
    mem_gnt_i = 1'b1;
    drive_store(1'b1, SW, 32'hA000, 32'h0000_000A); step();
    drive_store(1'b1, SH, 32'hB002, 32'h000B_0000);
    n_checks++; if (mem_addr_o !== 32'hA000 || mem_req_o !== 1'b1) begin n_fail++; $display("FAIL stream_0 got=%h req=%b exp=0000a000", mem_addr_o, mem_req_o); end
    step();
    drive_store(1'b1, SB, 32'hC002, 32'h00CC_0000);
    n_checks++; if (mem_addr_o !== 32'hB000 || mem_be_o !== 4'b1100) begin n_fail++; $display("FAIL stream_1 got=%h/%b exp=0000b000/1100", mem_addr_o, mem_be_o); end
    step();
    drive_store(1'b0, SB, 32'h0, 32'h0);
    n_checks++; if (mem_addr_o !== 32'hC000 || mem_be_o !== 4'b0100 || mem_wdata_o !== 32'h00CC_0000) begin n_fail++; $display("FAIL stream_2 got=%h/%b/%h exp=0000c000/0100/00cc0000", mem_addr_o, mem_be_o, mem_wdata_o); end
    step();
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL stream_empty got=%b exp=1", empty_o); end
    mem_gnt_i = 1'b0;
  endtask

  task automatic test_ld_conflict();
    mem_gnt_i = 1'b0;
    drive_store(1'b1, SB, 32'h1001, 32'h0000_5A00);
    ld_check_addr_i = 32'h1002; #1;
    n_checks++; if (ld_conflict_o !== 1'b0) begin n_fail++; $display("FAIL ld_enq_same_cycle got=%b exp=0", ld_conflict_o); end
    step();
    drive_store(1'b0, SB, 32'h0, 32'h0);
    n_checks++; if (ld_conflict_o !== 1'b1) begin n_fail++; $display("FAIL ld_hit got=%b exp=1", ld_conflict_o); end
    ld_check_addr_i = 32'h1004; #1;
    n_checks++; if (ld_conflict_o !== 1'b0) begin n_fail++; $display("FAIL ld_next_word got=%b exp=0", ld_conflict_o); end
    ld_check_addr_i = 32'h1002; mem_gnt_i = 1'b1; #1;
    n_checks++; if (ld_conflict_o !== 1'b1) begin n_fail++; $display("FAIL ld_retiring got=%b exp=1", ld_conflict_o); end
    step();
    n_checks++; if (ld_conflict_o !== 1'b0) begin n_fail++; $display("FAIL ld_after_drain got=%b exp=0", ld_conflict_o); end
    mem_gnt_i = 1'b0;
  endtask

  task automatic test_bad_funct3();
    mem_gnt_i = 1'b0;
    drive_store(1'b1, 3'b011, 32'h7000, 32'h7777_7777);
    n_checks++; if (st_ready_o !== 1'b1) begin n_fail++; $display("FAIL bad_ready got=%b exp=1", st_ready_o); end
    step();
    drive_store(1'b0, SW, 32'h0, 32'h0);
    n_checks++; if (st_ready_o !== 1'b1 || empty_o !== 1'b1 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL bad_no_enq got ready=%b empty=%b req=%b exp=1/1/0", st_ready_o, empty_o, mem_req_o); end
    step();
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL bad_no_req got=%b exp=0", mem_req_o); end
  endtask

  task automatic test_reset_mid();
    mem_gnt_i = 1'b0;
    drive_store(1'b1, SW, 32'h8000, 32'h1); step();
    drive_store(1'b1, SW, 32'h8004, 32'h2); step();
    drive_store(1'b1, SW, 32'h8008, 32'h3); step();
    drive_store(1'b0, SW, 32'h0, 32'h0);
    n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending got=%b exp=1", mem_req_o); end
    #2 rst_i = 1'b1;
    #1;
    n_checks++; if (mem_req_o !== 1'b0 || empty_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_async got req=%b empty=%b exp=0/1", mem_req_o, empty_o); end
    n_checks++; if (mem_addr_o !== 32'h0 || mem_be_o !== 4'b0) begin n_fail++; $display("FAIL rstmid_fields got=%h/%b exp=0/0", mem_addr_o, mem_be_o); end
    #1 rst_i = 1'b0;
    step(); step();
    n_checks++; if (mem_req_o !== 1'b0 || empty_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle got req=%b empty=%b exp=0/1", mem_req_o, empty_o); end
  endtask

  initial begin
    test_reset();
    test_single_sb();
    test_fill_order();
    test_full_simul();
    test_stream();
    test_ld_conflict();
    test_bad_funct3();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_mem_store_buffer.md
# mod_mem_store_buffer

Posted store buffer between the store data aligner and the data-memory port. It accepts one store per cycle from the memory stage: an unaligned byte address, funct3, and write data already lane-aligned by the store data aligner. It derives byte-enables, queues the store in a DEPTH-entry FIFO, and drains entries in order to data memory over a req/gnt handshake. It also flags loads that hit a word with a pending store, so the pipeline can stall the load until that store drains.

## Interface
Parameters:
- DEPTH, 4: number of FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- st_valid_i  in  1  store request from memory stage.
- st_ready_o  out  1  buffer can accept a store this cycle.
- st_funct3_i  in  `FUNCT3_WIDTH  store width (`FUNCT3_SB/SH/SW).
- st_addr_i  in  `XLEN  unaligned byte address.
- st_data_i  in  `XLEN  lane-aligned store data.
- mem_req_o  out  1  head entry presented to memory.
- mem_gnt_i  in  1  memory accepts presented entry.
- mem_addr_o  out  `XLEN  word address of head entry; bits [1:0] always 0.
- mem_wdata_o  out  `XLEN  data of head entry.
- mem_be_o  out  4  byte-enables of head entry.
- ld_check_addr_i  in  `XLEN  address of the load in the memory stage.
- ld_conflict_o  out  1  a pending entry targets the same word.
- empty_o  out  1  no pending entries (used by fence/drain logic).

## Operation
- Byte offset is st_addr_i[1:0]. Byte-enables are derived from funct3 as follows:
  - SB: 4'b0001 << offset.
  - SH: 4'b0011 if offset==0, else 4'b1100 (matches aligner placement).
  - SW: 4'b1111.
  - Any other funct3: the handshake completes, but nothing is enqueued.
- Enqueue:
  - Occurs when st_valid_i && st_ready_o and funct3 is valid.
  - The entry stores {st_addr_i[XLEN-1:2],2'b00}, st_data_i and be at the tail. The tail then advances.
- st_ready_o = !full. There is no same-cycle bypass: a full buffer refuses a store even if a grant frees a slot in that cycle.
- Drain:
  - mem_req_o = !empty. mem_addr_o, mem_wdata_o and mem_be_o are driven from the head entry.
  - When mem_req_o && mem_gnt_i, the head entry retires and the head advances.
  - While req is high and gnt is low, the presented fields must stay stable.
  - Order is strictly FIFO. Stores are never merged or reordered.
- Occupancy:
  - Pointers are log2(DEPTH)+1 bits wide. The extra MSB distinguishes full from empty.
  - full when the index bits are equal and the MSBs differ; empty when the pointers are equal.
  - Pointer wrap-around is natural modulo 2·DEPTH.
- Simultaneous enqueue and retire (not full, not empty): occupancy is unchanged and both pointers advance.
- ld_conflict_o = OR over valid entries of (entry word address == ld_check_addr_i[XLEN-1:2]).
  - The byte-enables are ignored; the match is conservative at word granularity.
  - The entry retiring in the current cycle still counts.
  - A store being enqueued in the current cycle does not count.
- empty_o = empty.

## Timing
- Reset values (applied immediately on rst_i, asynchronously):
  - Pointers = 0; empty_o=1; st_ready_o=1; mem_req_o=0; ld_conflict_o=0.
  - mem_addr_o, mem_wdata_o and mem_be_o = 0 (storage cleared).
- Reset mid-operation: all pending entries are discarded and mem_req_o drops without waiting for a grant.
- Latency: a store accepted at edge N is presented with mem_req_o=1 after edge N (cycle N+1) when the buffer was empty.
- Throughput: one enqueue and one retire per cycle. With gnt held high, a stream of stores flows through at 1/cycle with 1-cycle latency.
- st_ready_o, mem_req_o, empty_o and the mem_* outputs depend only on registered state, with no combinational path from inputs.
- ld_conflict_o is combinational from ld_check_addr_i and registered state.
- Entries do not change between cycles except on enqueue or retire.

## Test plan
- Reset, then SB to 0x1003 with data 0xAB000000, gnt=1:
  - st_ready_o=1.
  - Next cycle: mem_req_o=1, mem_addr_o=0x1000, mem_be_o=4'b1000, mem_wdata_o=0xAB000000.
  - Following cycle: empty_o=1.
- With gnt=0, enqueue SH@0x2002, SW@0x3000, SB@0x4001, SH@0x5000:
  - st_ready_o=0 after the 4th store; a 5th store is refused.
  - Raise gnt: retire order and byte-enables are 1100, 1111, 0010, 0011.
- With the buffer full, st_valid_i=1 and gnt=1 in the same cycle: no enqueue that cycle, the head retires, and st_ready_o=1 on the next cycle.
- Pending SB@0x1001 and ld_check_addr_i=0x1002 -> ld_conflict_o=1; ld_check_addr_i=0x1004 -> 0. After the store is granted, 0x1002 -> 0.
- funct3=3'b011 with st_valid_i=1 -> st_ready_o stays 1, empty_o stays 1, and no mem_req_o is issued.
- Three entries pending with gnt=0, then rst_i pulsed between edges -> mem_req_o=0 and empty_o=1 immediately; after reset, no request is issued without a new store.
